// File: rtl/operand_fetch.sv
// Operand fetch sequencer: walks a word-address range of the combinational data
// memory and hands each 128-bit word to the FPU as a classified pair of doubles.
module operand_fetch #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       count,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [DATA_W/2-1:0]   op_a,
  output logic [DATA_W/2-1:0]   op_b,
  output logic [3:0]            op_a_cls,
  output logic [3:0]            op_b_cls,
  output logic [ADDR_W-1:0]     op_index,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remaining;

  // {nan, inf, zero, denorm}; the sign bit plays no part
  function automatic logic [3:0] classify(input logic [HALF_W-1:0] v);
    logic [10:0] exp;
    logic [51:0] mant;
    exp  = v[62:52];
    mant = v[51:0];
    return {(exp == '1) && (mant != '0),
            (exp == '1) && (mant == '0),
            (exp == '0) && (mant == '0),
            (exp == '0) && (mant != '0)};
  endfunction

  assign mem_addr = addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_reg  <= '0;
      remaining <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_a_cls  <= '0;
      op_b_cls  <= '0;
      op_index  <= '0;
      op_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            addr_reg  <= base_addr;
            remaining <= count;
            busy      <= 1'b1;
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            op_a     <= mem_data[DATA_W-1:HALF_W];
            op_b     <= mem_data[HALF_W-1:0];
            op_a_cls <= classify(mem_data[DATA_W-1:HALF_W]);
            op_b_cls <= classify(mem_data[HALF_W-1:0]);
            op_index <= addr_reg;
            op_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // abort takes priority: a pair offered in the abort cycle is not accepted
          if (abort) begin
            state    <= IDLE;
            op_valid <= 1'b0;
            busy     <= 1'b0;
          end else if (op_ready) begin
            op_valid  <= 1'b0;
            remaining <= remaining - 1'b1;
            if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              addr_reg <= addr_reg + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a behavioural memory plus a run-level reference model
// predicting every pair, its class flags and the handshake/done timing.
module tb_operand_fetch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [12:0]  base_addr = '0;
  logic [13:0]  count = '0;
  logic [12:0]  mem_addr;
  logic [127:0] mem_data;
  logic [63:0]  op_a, op_b;
  logic [3:0]   op_a_cls, op_b_cls;
  logic [12:0]  op_index;
  logic         op_valid;
  logic         op_ready = 1'b0;
  logic         busy, done;

  logic [127:0] mem [8192];
  int vectors = 0;
  int miscompares = 0;

  operand_fetch #(.ADDR_W(13), .DATA_W(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .mem_addr(mem_addr),
    .mem_data(mem_data), .op_a(op_a), .op_b(op_b),
    .op_a_cls(op_a_cls), .op_b_cls(op_b_cls), .op_index(op_index),
    .op_valid(op_valid), .op_ready(op_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign mem_data = mem[mem_addr];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] cls_of(input logic [63:0] v);
    int unsigned e;
    longint unsigned m;
    e = int'((v >> 52) & 64'h7FF);
    m = v & 64'h000F_FFFF_FFFF_FFFF;
    if (e == 2047) return (m != 0) ? 4'b1000 : 4'b0100;
    if (e == 0)    return (m != 0) ? 4'b0001 : 4'b0010;
    return 4'b0000;
  endfunction

  // random doubles biased towards the special exponents and zero mantissas
  function automatic logic [63:0] rand_dbl();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: v[62:52] = 11'h000;
      1: v[62:52] = 11'h7FF;
      2: begin v[62:52] = 11'h000; v[51:0] = '0; end
      3: begin v[62:52] = 11'h7FF; v[51:0] = '0; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, op_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One run: stall_lo..stall_hi cycles of op_ready low before each accept;
  // abort is raised together with op_ready on pair index abort_pair (-1 = never).
  task automatic do_run(input int base, input int cnt, input int stall_lo,
                        input int stall_hi, input int abort_pair);
    int a, k;
    logic [63:0] ea, eb;
    @(negedge clk);
    start = 1'b1; base_addr = base[12:0]; count = cnt[13:0];
    @(posedge clk); #1;
    start = 1'b0; base_addr = 13'($urandom); count = 14'($urandom);
    if (cnt == 0) begin
      @(negedge clk);
      check("zero_done", done, 1);
      check("zero_valid", op_valid, 0);
      @(negedge clk);
      check_idle_outputs("zero_end");
      return;
    end
    for (int i = 0; i < cnt; i++) begin
      a  = (base + i) % 8192;
      ea = mem[a][127:64];
      eb = mem[a][63:0];
      @(negedge clk);
      check("fetch_busy", busy, 1);
      check("fetch_valid", op_valid, 0);
      check("fetch_addr", mem_addr, a[12:0]);
      k = $urandom_range(stall_lo, stall_hi);
      for (int s = 0; s <= k; s++) begin
        @(negedge clk);
        check("hold_valid", op_valid, 1);
        check("op_a", op_a, ea);
        check("op_b", op_b, eb);
        check("op_a_cls", op_a_cls, cls_of(ea));
        check("op_b_cls", op_b_cls, cls_of(eb));
        check("op_index", op_index, a[12:0]);
        check("hold_done", done, 0);
      end
      op_ready = 1'b1;
      abort = (i == abort_pair);
      @(posedge clk); #1;
      op_ready = 1'b0;
      abort = 1'b0;
      if (i == abort_pair) begin
        @(negedge clk);
        check_idle_outputs("abort");
        @(negedge clk);
        check_idle_outputs("abort_after");
        return;
      end
      if (i == cnt - 1) begin
        @(negedge clk);
        check("end_done", done, 1);
        check("end_valid", op_valid, 0);
        check("end_busy", busy, 1);
        @(negedge clk);
        check_idle_outputs("end_idle");
      end
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    start = 1'b1; base_addr = 13'd5; count = 14'd3;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_valid", op_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_op_a", op_a, 0);
    check("rst_op_b", op_b, 0);
    check("rst_cls", {op_a_cls, op_b_cls}, 0);
    check("rst_index", op_index, 0);
    check("rst_mem_addr", mem_addr, 0);
    check_idle_outputs("rst");
    @(posedge clk); #1;
    check_idle_outputs("rst_held");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_release");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c, ap;
    for (int i = 0; i < 8192; i++) mem[i] = {rand_dbl(), rand_dbl()};
    mem[8] = {64'h3FF0000000000000, 64'h4000000000000000};
    mem[2] = {64'h0000000000000001, 64'h800FFFFFFFFFFFFF};
    mem[3] = {64'h7FF0000000000000, 64'hFFF0000000000000};
    mem[4] = {64'h7FF8000000000000, 64'hFFF0000000000001};
    mem[5] = {64'h0000000000000000, 64'h8000000000000000};

    #1;
    check("reset_op_a", op_a, 0);
    check("reset_op_b", op_b, 0);
    check("reset_cls", {op_a_cls, op_b_cls}, 0);
    check("reset_index", op_index, 0);
    check("reset_mem_addr", mem_addr, 0);
    check_idle_outputs("reset");
    #20;
    @(negedge clk) rst_n = 1'b1;

    do_run(8, 1, 0, 0, -1);
    check("dir8_cls", {op_a_cls, op_b_cls}, 8'h00);
    do_run(2, 3, 0, 1, -1);
    do_run(8191, 2, 0, 2, -1);
    check("wrap_index", op_index, 13'd0);
    do_run(5, 1, 10, 10, -1);
    check("neg_zero_cls", {op_a_cls, op_b_cls}, 8'h22);
    do_run(9, 4, 0, 2, 1);
    do_run(9, 4, 0, 2, -1);
    do_run(0, 0, 0, 0, -1);

    // abort beats start in IDLE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_abort");

    reset_mid_run();
    do_run(8190, 4, 0, 1, -1);

    for (int r = 0; r < 25; r++) begin
      b  = $urandom_range(0, 8191);
      c  = $urandom_range(0, 5);
      ap = ($urandom_range(0, 3) == 0 && c > 0) ? $urandom_range(0, c - 1) : -1;
      do_run(b, c, 0, 3, ap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
